mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter that shares one unified, byte-lane, synchronous-read memory between the CPU instruction-fetch port and the data-access port. It sits between the CPU and the memory under `top`, replacing separate instruction and data memories. It grants at most one access per cycle, with data priority and a starvation guard for fetch. It routes the one-cycle-latency read data back to the owning requester.

## Interface
Parameters:
- ADDR_W, 14, word-address width (16K words; covers word 0x3FFF)
- DATA_W, 32, data width; byte lanes = DATA_W/8
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch wins once

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch request, held until i_gnt
- i_addr  in  ADDR_W  fetch word address
- i_flush  in  1  cancel any in-flight fetch response (branch/jump)
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DATA_W  fetch data; 0 when i_rvalid=0
- d_req  in  1  data request, held until d_gnt
- d_we  in  DATA_W/8  byte write enables; all-zero = read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data, lane-aligned
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  data read valid; never asserted for writes
- d_rdata  out  DATA_W  data read result; 0 when d_rvalid=0
- mem_cs  out  1  memory access this cycle
- mem_we  out  DATA_W/8  byte write enables to memory
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read with mem_cs=1

## Operation
- Grant logic is combinational from requests and registered state. Exactly one of i_gnt or d_gnt is asserted, or neither.
- Priority: d_req wins. When both request and starve_cnt == STARVE_LIMIT, fetch wins.
- starve_cnt: increments, saturating at STARVE_LIMIT, on cycles with i_req & ~i_gnt. It clears to 0 on i_gnt or ~i_req.
- Memory port on grant: mem_cs=1 and mem_addr = granted address.
  - Fetch grant: mem_we = 0.
  - Data grant: mem_we = d_we, mem_wdata = d_wdata.
  - No grant: mem_cs=0, mem_we=0, mem_addr/mem_wdata = 0.
- Response tracking: register resp_own ∈ {NONE, INST, DATA} is loaded each cycle.
  - INST on fetch grant.
  - DATA on data-read grant (d_we==0).
  - NONE otherwise, which includes data writes.
- Next cycle: resp_own==INST gives i_rvalid=1 and i_rdata=mem_rdata. resp_own==DATA gives d_rvalid=1 and d_rdata=mem_rdata.
- Write completion is d_gnt itself; no response follows.
- i_flush=1: forces resp_own from INST to NONE.
  - An i_rvalid due in the same cycle as i_flush is suppressed.
  - A fetch granted in the same cycle as i_flush produces no response.
  - Grants themselves are unaffected.
- Back-to-back grants every cycle are legal; the response for grant N overlaps with grant N+1.

## Timing
- Reset values: i_gnt=d_gnt=0, i_rvalid=d_rvalid=0, i_rdata=d_rdata=0, mem_cs=0, mem_we=0, resp_own=NONE, starve_cnt=0.
- Grant latency: 0 cycles (same cycle as req).
- Read-data latency: 1 cycle after the grant.
- Throughput: 1 access per cycle.
- Worst-case fetch wait under continuous d_req: STARVE_LIMIT cycles denied, then granted on cycle STARVE_LIMIT+1.
- Reset mid-operation: any pending response is dropped, with no rvalid after rst deasserts. The counter clears.
- Requests deasserted before grant are legal (cancelled); no state changes.
- The same address written by data and fetched the following cycle returns the new value. This is a memory property; the arbiter adds no bypass.

## Structure
- Package mem_arb_pkg:
  - owner_e enum {OWN_NONE, OWN_INST, OWN_DATA}.
  - Default ADDR_W/DATA_W localparams.
- Sub-module arb_starve_cnt: saturating counter with inc/clr inputs and a `hit` output (cnt==STARVE_LIMIT). Its width is $clog2(STARVE_LIMIT+1).
- The rest (grant mux, resp_own register, data routing) lives in mem_arbiter.

## Test plan
- Fetch only: i_req=1 at i_addr=0x0000..0x0003 with memory preloaded with 0x11111111..0x44444444 → i_gnt each cycle; i_rvalid one cycle later with matching words; d_rvalid=0 throughout.
- Data write then read: d_we=4'b0011, d_addr=0x2000, d_wdata=0xAABBCCDD over memory 0x12345678, then a read at 0x2000 → d_gnt both cycles, no d_rvalid after the write; d_rdata=0x1234CCDD on the cycle after the read grant.
- Starvation: d_req and i_req held high for 10 cycles with STARVE_LIMIT=4 → d_gnt cycles 1–4, i_gnt cycle 5, d_gnt cycles 6–9, i_gnt cycle 10.
- Flush: fetch granted at 0x0010 with i_flush=1 the next cycle → i_rvalid stays 0; a fetch granted with i_flush high in the same cycle also yields no i_rvalid.
- Reset mid-read: d_read granted, then rst pulsed before the response cycle → d_rvalid=0, all outputs at reset values, starve_cnt=0.
- End-marker write: d_we=4'b1111, d_addr=0x3FFF, d_wdata=0xFFFFFFFF → mem_cs=1, mem_we=4'hF, mem_addr=0x3FFF in the grant cycle; the word reads back as 0xFFFFFFFF.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF       = 14;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  // Owner of the read response returning in the cycle after a grant.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  function automatic logic is_read(input logic [DATA_W_DEF/8-1:0] we);
    return (we == '0);
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive denied fetch cycles; hit flags that fetch must win next.
module arb_starve_cnt #(
  parameter int LIMIT = mem_arb_pkg::STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIM)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read, byte-lane memory between fetch and data ports.
// Data has priority; a saturating starvation counter lets fetch through once.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_flush,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,

  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,

  output logic                mem_cs,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int NB = DATA_W / 8;

  logic   starve_hit;
  owner_e resp_own, resp_own_nxt;
  logic   d_is_read;

  arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (i_req & ~i_gnt),
    .clr (i_gnt | ~i_req),
    .hit (starve_hit)
  );

  assign i_gnt     = i_req & (~d_req | starve_hit);
  assign d_gnt     = d_req & ~i_gnt;
  assign d_is_read = (d_we == '0);

  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (i_gnt) begin
      mem_cs   = 1'b1;
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_cs    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // A fetch granted under flush belongs to the abandoned path, so no owner is recorded.
  always_comb begin
    resp_own_nxt = OWN_NONE;
    if (i_gnt && !i_flush) begin
      resp_own_nxt = OWN_INST;
    end else if (d_gnt && d_is_read) begin
      resp_own_nxt = OWN_DATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_own <= OWN_NONE;
    end else begin
      resp_own <= resp_own_nxt;
    end
  end

  assign i_rvalid = (resp_own == OWN_INST) & ~i_flush;
  assign d_rvalid = (resp_own == OWN_DATA);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

  logic unused_nb;
  assign unused_nb = (NB == 0);

endmodule
